pcileech_sys_ctl: RTL and testbench

- System reset sequencer and front-panel controller for the AC701 FT601 top level.
- Consumes raw gpio_sw_north/gpio_sw_south and raw activity levels from the COM and PCIe cores.
- Produces the sequenced system reset for pcileech_com, pcileech_fifo and pcileech_pcie_a7x4, the FT601 chip reset, a debounced LED-invert control, a free-running tickcount and the three board LEDs.
- Sits directly upstream of every core instantiated in the top level.

---
 rtl/pcileech_sys_ctl_if.sv | 25 ++
 rtl/pcileech_sys_ctl.sv | 165 ++++++++++++++++
 tb/tb_pcileech_sys_ctl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_sys_ctl_if.sv
// Signal bundle between the system controller and the top level: raw buttons and
// activity levels in, sequenced resets, LED controls, tick counter and state out.
interface pcileech_sys_ctl_if;
  logic        btn_north_raw;
  logic        btn_south_raw;
  logic        act_com;
  logic        act_pcie;
  logic        rst_sys;
  logic        ft601_rst_n;
  logic        btn_invert;
  logic [63:0] tickcount64;
  logic [2:0]  gpio_led;
  logic [1:0]  dbg_state;

  // All signals are plain levels sampled on clk; there is no valid/ready handshake.
  modport master (
    output btn_north_raw, btn_south_raw, act_com, act_pcie,
    input  rst_sys, ft601_rst_n, btn_invert, tickcount64, gpio_led, dbg_state
  );

  modport slave (
    input  btn_north_raw, btn_south_raw, act_com, act_pcie,
    output rst_sys, ft601_rst_n, btn_invert, tickcount64, gpio_led, dbg_state
  );
endinterface

// File: rtl/pcileech_sys_ctl.sv
// Reset sequencer and front-panel controller (debounced buttons, tick counter, LEDs).
// Define PCILEECH_SYS_CTL_LED_STRETCH_EN to build the LED minimum on-time counters.
module pcileech_sys_ctl #(
  parameter int unsigned POR_CYCLES          = 64,
  parameter int unsigned FT601_SETTLE_CYCLES = 32,
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned LED_STRETCH_CYCLES  = 5000000,
  parameter int unsigned HEARTBEAT_BIT       = 26
) (
  input  logic               clk,
  input  logic               rst,
  pcileech_sys_ctl_if.slave  bus
);

  localparam int unsigned SEQ_MAX = (POR_CYCLES > FT601_SETTLE_CYCLES) ? POR_CYCLES
                                                                       : FT601_SETTLE_CYCLES;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_POR    = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [SEQ_W-1:0]  seq_cnt, seq_cnt_n;
  logic              rst_sys_q;
  logic              ft601_rst_n_q;
  logic [63:0]       tick_q;
  logic [2:0]        led_q;

  // Bit 0 is the north (reset) button, bit 1 the south (invert) button.
  logic [1:0]        sync1, sync2, db;
  logic [DB_W-1:0]   db_cnt [2];

  logic              str_com, str_pcie;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {bus.btn_south_raw, bus.btn_north_raw};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A held north button overrides any sequence step, including a same-cycle expiry.
  always_comb begin
    state_n   = state;
    seq_cnt_n = seq_cnt;
    if (db[0]) begin
      state_n   = S_HOLD;
      seq_cnt_n = '0;
    end else begin
      case (state)
        S_POR: begin
          if (seq_cnt == SEQ_W'(POR_CYCLES - 1)) begin
            state_n   = S_SETTLE;
            seq_cnt_n = '0;
          end else begin
            seq_cnt_n = seq_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (seq_cnt == SEQ_W'(FT601_SETTLE_CYCLES - 1)) begin
            state_n   = S_RUN;
            seq_cnt_n = '0;
          end else begin
            seq_cnt_n = seq_cnt + 1'b1;
          end
        end
        S_RUN: begin
          seq_cnt_n = '0;
        end
        S_HOLD: begin
          state_n   = S_POR;
          seq_cnt_n = '0;
        end
        default: begin
          state_n   = S_POR;
          seq_cnt_n = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the transition edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_POR;
      seq_cnt       <= '0;
      rst_sys_q     <= 1'b1;
      ft601_rst_n_q <= 1'b0;
    end else begin
      state         <= state_n;
      seq_cnt       <= seq_cnt_n;
      rst_sys_q     <= (state_n != S_RUN);
      ft601_rst_n_q <= (state_n == S_SETTLE) || (state_n == S_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tick_q <= '0;
    else     tick_q <= tick_q + 64'd1;
  end

`ifdef PCILEECH_SYS_CTL_LED_STRETCH_EN
  localparam int unsigned ST_W = $clog2(LED_STRETCH_CYCLES + 1);

  logic [ST_W-1:0] str_cnt [2];
  logic [1:0]      act;

  assign act = {bus.act_pcie, bus.act_com};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || rst_sys_q) begin
        str_cnt[i] <= '0;
      end else if (act[i]) begin
        str_cnt[i] <= ST_W'(LED_STRETCH_CYCLES);
      end else if (str_cnt[i] != '0) begin
        str_cnt[i] <= str_cnt[i] - 1'b1;
      end
    end
  end

  assign str_com  = (str_cnt[0] != '0);
  assign str_pcie = (str_cnt[1] != '0);
`else
  assign str_com  = bus.act_com;
  assign str_pcie = bus.act_pcie;
`endif

  // LEDs are active-low; reset leaves them all dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 3'b111;
    end else begin
      led_q <= {~str_pcie, ~(str_com ^ db[1]), tick_q[HEARTBEAT_BIT] ^ db[1] ^ db[0]};
    end
  end

  assign bus.rst_sys     = rst_sys_q;
  assign bus.ft601_rst_n = ft601_rst_n_q;
  assign bus.btn_invert  = db[1];
  assign bus.tickcount64 = tick_q;
  assign bus.gpio_led    = led_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_pcileech_sys_ctl.sv
// Directed bench for pcileech_sys_ctl: reset sequencing, debounce, precedence,
// LED activity/invert and tick counter wrap, with small parameter values.
`timescale 1ns/1ps
module tb_pcileech_sys_ctl;
  localparam int unsigned POR     = 4;
  localparam int unsigned SETTLE  = 3;
  localparam int unsigned DEB     = 5;
  localparam int unsigned STRETCH = 8;
  localparam int unsigned HB      = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [63:0] exp_tick = '0;
  logic [63:0] prev;

  pcileech_sys_ctl_if bus ();

  pcileech_sys_ctl #(
    .POR_CYCLES(POR), .FT601_SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB),
    .LED_STRETCH_CYCLES(STRETCH), .HEARTBEAT_BIT(HB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) exp_tick = '0;
    else     exp_tick = exp_tick + 64'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_north_raw = 1'b0;
    bus.btn_south_raw = 1'b0;
    bus.act_com = 1'b0;
    bus.act_pcie = 1'b0;
    repeat (3) step();
    checks++; if (bus.rst_sys !== 1'b1) $display("FAIL reset_rst_sys got %b want 1", bus.rst_sys); else passes++;
    checks++; if (bus.ft601_rst_n !== 1'b0) $display("FAIL reset_ft601 got %b want 0", bus.ft601_rst_n); else passes++;
    checks++; if (bus.btn_invert !== 1'b0) $display("FAIL reset_invert got %b want 0", bus.btn_invert); else passes++;
    checks++; if (bus.tickcount64 !== 64'd0) $display("FAIL reset_tick got %0h want 0", bus.tickcount64); else passes++;
    checks++; if (bus.gpio_led !== 3'b111) $display("FAIL reset_led got %b want 111", bus.gpio_led); else passes++;
    checks++; if (bus.dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.dbg_state); else passes++;
  endtask

  task automatic test_por_sequence();
    logic [1:0] es;
    rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      es = (n < 4) ? 2'd0 : (n < 7) ? 2'd1 : 2'd2;
      checks++; if (bus.ft601_rst_n !== (n >= 4)) $display("FAIL por_ft601 n=%0d got %b want %b", n, bus.ft601_rst_n, (n >= 4)); else passes++;
      checks++; if (bus.rst_sys !== (n < 7)) $display("FAIL por_rst_sys n=%0d got %b want %b", n, bus.rst_sys, (n < 7)); else passes++;
      checks++; if (bus.tickcount64 !== exp_tick) $display("FAIL por_tick n=%0d got %0h want %0h", n, bus.tickcount64, exp_tick); else passes++;
      checks++; if (bus.dbg_state !== es) $display("FAIL por_state n=%0d got %0d want %0d", n, bus.dbg_state, es); else passes++;
      if (n == 1) begin
        checks++; if (bus.gpio_led !== 3'b110) $display("FAIL por_led_first got %b want 110", bus.gpio_led); else passes++;
      end
    end
  endtask

  task automatic test_heartbeat();
    for (int i = 0; i < 16; i++) begin
      step();
      prev = exp_tick - 64'd1;
      checks++; if (bus.gpio_led !== {2'b11, prev[HB]}) $display("FAIL heartbeat i=%0d got %b want %b", i, bus.gpio_led, {2'b11, prev[HB]}); else passes++;
    end
  endtask

  task automatic test_north_glitch();
    for (int i = 0; i < 16; i++) begin
      bus.btn_north_raw = (i < 4);
      step();
      checks++; if (bus.rst_sys !== 1'b0) $display("FAIL glitch_rst_sys i=%0d got %b want 0", i, bus.rst_sys); else passes++;
    end
    checks++; if (bus.dbg_state !== 2'd2) $display("FAIL glitch_state got %0d want 2", bus.dbg_state); else passes++;
  endtask

  task automatic test_north_hold();
    logic [1:0] es;
    for (int n = 1; n <= 10; n++) begin
      bus.btn_north_raw = 1'b1;
      step();
      es = (n >= 8) ? 2'd3 : 2'd2;
      checks++; if (bus.rst_sys !== (n >= 8)) $display("FAIL hold_rst_sys n=%0d got %b want %b", n, bus.rst_sys, (n >= 8)); else passes++;
      checks++; if (bus.ft601_rst_n !== (n < 8)) $display("FAIL hold_ft601 n=%0d got %b want %b", n, bus.ft601_rst_n, (n < 8)); else passes++;
      checks++; if (bus.dbg_state !== es) $display("FAIL hold_state n=%0d got %0d want %0d", n, bus.dbg_state, es); else passes++;
      if (n >= 8) begin
        prev = exp_tick - 64'd1;
        checks++; if (bus.gpio_led[0] !== ~prev[HB]) $display("FAIL hold_led0 n=%0d got %b want %b", n, bus.gpio_led[0], ~prev[HB]); else passes++;
      end
    end
    bus.btn_north_raw = 1'b0;
    for (int m = 1; m <= 18; m++) begin
      step();
      es = (m < 8) ? 2'd3 : (m < 12) ? 2'd0 : (m < 15) ? 2'd1 : 2'd2;
      checks++; if (bus.dbg_state !== es) $display("FAIL release_state m=%0d got %0d want %0d", m, bus.dbg_state, es); else passes++;
      checks++; if (bus.ft601_rst_n !== (m >= 12)) $display("FAIL release_ft601 m=%0d got %b want %b", m, bus.ft601_rst_n, (m >= 12)); else passes++;
      checks++; if (bus.rst_sys !== (m < 15)) $display("FAIL release_rst_sys m=%0d got %b want %b", m, bus.rst_sys, (m < 15)); else passes++;
    end
  endtask

  task automatic test_settle_collision();
    bus.btn_north_raw = 1'b1;
    repeat (10) step();
    // Re-press timed so the debounced press lands on the settle-expiry edge.
    for (int m = 1; m <= 20; m++) begin
      bus.btn_north_raw = (m >= 8);
      step();
      checks++; if (bus.rst_sys !== 1'b1) $display("FAIL collide_rst_sys m=%0d got %b want 1", m, bus.rst_sys); else passes++;
      if (m == 14) begin
        checks++; if (bus.dbg_state !== 2'd1) $display("FAIL collide_pre_state got %0d want 1", bus.dbg_state); else passes++;
        checks++; if (bus.ft601_rst_n !== 1'b1) $display("FAIL collide_pre_ft601 got %b want 1", bus.ft601_rst_n); else passes++;
      end
      if (m == 15) begin
        checks++; if (bus.dbg_state !== 2'd3) $display("FAIL collide_state got %0d want 3", bus.dbg_state); else passes++;
        checks++; if (bus.ft601_rst_n !== 1'b0) $display("FAIL collide_ft601 got %b want 0", bus.ft601_rst_n); else passes++;
      end
    end
    bus.btn_north_raw = 1'b0;
    repeat (20) step();
    checks++; if (bus.dbg_state !== 2'd2) $display("FAIL collide_recover_state got %0d want 2", bus.dbg_state); else passes++;
    checks++; if (bus.rst_sys !== 1'b0) $display("FAIL collide_recover_rst_sys got %b want 0", bus.rst_sys); else passes++;
  endtask

  task automatic test_rst_mid_settle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    checks++; if (bus.dbg_state !== 2'd1) $display("FAIL mid_pre_state got %0d want 1", bus.dbg_state); else passes++;
    checks++; if (bus.ft601_rst_n !== 1'b1) $display("FAIL mid_pre_ft601 got %b want 1", bus.ft601_rst_n); else passes++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.ft601_rst_n !== 1'b0) $display("FAIL mid_ft601 got %b want 0", bus.ft601_rst_n); else passes++;
    checks++; if (bus.rst_sys !== 1'b1) $display("FAIL mid_rst_sys got %b want 1", bus.rst_sys); else passes++;
    checks++; if (bus.dbg_state !== 2'd0) $display("FAIL mid_state got %0d want 0", bus.dbg_state); else passes++;
    checks++; if (bus.tickcount64 !== 64'd0) $display("FAIL mid_tick got %0h want 0", bus.tickcount64); else passes++;
    for (int n = 1; n <= 7; n++) begin
      step();
      checks++; if (bus.ft601_rst_n !== (n >= 4)) $display("FAIL mid_seq_ft601 n=%0d got %b want %b", n, bus.ft601_rst_n, (n >= 4)); else passes++;
      checks++; if (bus.rst_sys !== (n < 7)) $display("FAIL mid_seq_rst_sys n=%0d got %b want %b", n, bus.rst_sys, (n < 7)); else passes++;
    end
  endtask

  task automatic test_led_activity();
    logic e1, e2;
    for (int k = 0; k < 16; k++) begin
      bus.act_com  = (k == 0) || (k == 5);
      bus.act_pcie = (k == 0);
      step();
`ifdef PCILEECH_SYS_CTL_LED_STRETCH_EN
      e1 = !((k + 1) >= 2 && (k + 1) <= 14);
      e2 = !((k + 1) >= 2 && (k + 1) <= 9);
`else
      e1 = !((k + 1) == 1 || (k + 1) == 6);
      e2 = !((k + 1) == 1);
`endif
      checks++; if (bus.gpio_led[1] !== e1) $display("FAIL led_com t=%0d got %b want %b", k + 1, bus.gpio_led[1], e1); else passes++;
      checks++; if (bus.gpio_led[2] !== e2) $display("FAIL led_pcie t=%0d got %b want %b", k + 1, bus.gpio_led[2], e2); else passes++;
    end
    bus.act_com  = 1'b0;
    bus.act_pcie = 1'b0;
  endtask

  task automatic test_invert();
    for (int n = 1; n <= 10; n++) begin
      bus.btn_south_raw = 1'b1;
      step();
      checks++; if (bus.btn_invert !== (n >= 7)) $display("FAIL invert n=%0d got %b want %b", n, bus.btn_invert, (n >= 7)); else passes++;
      checks++; if (bus.gpio_led[1] !== (n < 8)) $display("FAIL invert_led1 n=%0d got %b want %b", n, bus.gpio_led[1], (n < 8)); else passes++;
      if (n >= 8) begin
        prev = exp_tick - 64'd1;
        checks++; if (bus.gpio_led[0] !== ~prev[HB]) $display("FAIL invert_led0 n=%0d got %b want %b", n, bus.gpio_led[0], ~prev[HB]); else passes++;
      end
    end
  endtask

  task automatic test_tick_wrap();
    force dut.tick_q = 64'hFFFF_FFFF_FFFF_FFFD;
    step();
    release dut.tick_q;
    exp_tick = 64'hFFFF_FFFF_FFFF_FFFD;
    checks++; if (bus.tickcount64 !== exp_tick) $display("FAIL wrap_load got %0h want %0h", bus.tickcount64, exp_tick); else passes++;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.tickcount64 !== exp_tick) $display("FAIL wrap_tick i=%0d got %0h want %0h", i, bus.tickcount64, exp_tick); else passes++;
      checks++; if (bus.rst_sys !== 1'b0) $display("FAIL wrap_rst_sys i=%0d got %b want 0", i, bus.rst_sys); else passes++;
      checks++; if (bus.dbg_state !== 2'd2) $display("FAIL wrap_state i=%0d got %0d want 2", i, bus.dbg_state); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_por_sequence();
    test_heartbeat();
    test_north_glitch();
    test_north_hold();
    test_settle_collision();
    test_rst_mid_settle();
    repeat (4) step();
    test_led_activity();
    test_invert();
    test_tick_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
